// File: rtl/mem_ctrl.sv
`timescale 1ns/1ps
// mem_ctrl -- CPU load/store front end for a single-port synchronous SRAM.
//
// Accepts one CPU request at a time. Each request is either faulted
// immediately or issued to the SRAM as one word-wide access with byte-lane
// enables. Load data is lane-selected and extended, then held on 'out'
// until the next successful load.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous reset, active low
//   rd, we      CPU load / store request (only seen while idle)
//   addr        CPU byte address
//   data        CPU store data, right-aligned
//   size        00 byte, 01 half, 10 word, 11 illegal
//   sign        load extension: 0 sign-extend, 1 zero-extend
//   out         formatted load result (held)
//   error       access fault, meaningful while ready=1
//   ready       one-cycle completion pulse
//   sram_en     SRAM access strobe
//   sram_we     SRAM write strobe (only with sram_en)
//   sram_addr   SRAM word address
//   sram_be     SRAM byte-lane enables
//   sram_wdata  lane-replicated store data
//   sram_rdata  SRAM read data, valid LATENCY cycles after sram_en

module mem_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] out,
  output logic        error,
  output logic        ready,
  output logic        sram_en,
  output logic        sram_we,
  output logic [29:0] sram_addr,
  output logic [3:0]  sram_be,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic        rd_q;
  logic        we_q;
  logic        fault_q;
  logic [3:0]  cnt;
  logic        accept;
  logic        fault_in;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt;

  assign accept = (state == IDLE) && (rd || we);

  // Fault decode on the live request; only meaningful in the accept cycle.
  always_comb begin
    fault_in = rd && we;
    case (size)
      2'b01:   if (addr[0]) fault_in = 1'b1;
      2'b10:   if (addr[1:0] != 2'b00) fault_in = 1'b1;
      2'b11:   fault_in = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Faults skip the SRAM entirely; stores need no wait phase.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fault_in ? RESP : ISSUE;
      ISSUE:   state_next = rd_q ? WAIT : RESP;
      WAIT:    if (cnt == 4'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and the held load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= 32'd0;
      data_q  <= 32'd0;
      size_q  <= 2'b00;
      sign_q  <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      cnt     <= 4'd0;
      out     <= 32'd0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        data_q  <= data;
        size_q  <= size;
        sign_q  <= sign;
        rd_q    <= rd;
        we_q    <= we;
        fault_q <= fault_in;
      end
      if (state == ISSUE) cnt <= CNT_INIT;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      // Last WAIT cycle is exactly when the SRAM presents the read word.
      if (state == WAIT && cnt == 4'd0) out <= load_fmt;
    end
  end

  // Lane select and extension of the returning word.
  always_comb begin
    lane_b = sram_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    lane_b = sram_rdata[15:8];
      2'd2:    lane_b = sram_rdata[23:16];
      2'd3:    lane_b = sram_rdata[31:24];
      default: ;
    endcase
    lane_h = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (size_q)
      2'b00:   load_fmt = {{24{~sign_q & lane_b[7]}}, lane_b};
      2'b01:   load_fmt = {{16{~sign_q & lane_h[15]}}, lane_h};
      default: load_fmt = sram_rdata;
    endcase
  end

  // Byte enables only while strobing; store data replicated to every lane
  // so the SRAM picks the right bytes via sram_be alone.
  always_comb begin
    sram_be = 4'b0000;
    if (state == ISSUE) begin
      case (size_q)
        2'b00:   sram_be = 4'b0001 << addr_q[1:0];
        2'b01:   sram_be = addr_q[1] ? 4'b1100 : 4'b0011;
        2'b10:   sram_be = 4'b1111;
        default: sram_be = 4'b0000;
      endcase
    end
    case (size_q)
      2'b00:   sram_wdata = {4{data_q[7:0]}};
      2'b01:   sram_wdata = {2{data_q[15:0]}};
      default: sram_wdata = data_q;
    endcase
  end

  assign sram_en   = (state == ISSUE);
  assign sram_we   = (state == ISSUE) && we_q;
  assign sram_addr = addr_q[31:2];
  assign ready     = (state == RESP);
  assign error     = (state == RESP) && fault_q;

endmodule

// File: tb/tb_mem_ctrl.sv
`timescale 1ns/1ps
// tb_mem_ctrl -- self-checking bench for mem_ctrl.
// A transaction-level model predicts, per cycle, what the controller must
// show on its outputs; a compare process checks it every cycle. Directed
// vectors carry hand-computed results that pin the model down. Two extra
// instances with LATENCY 1 and 15 run back-to-back loads forever and have
// their completion spacing measured.

module tb_mem_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data = 32'd0;
  logic [1:0]  size = 2'b00;
  logic        sign = 1'b0;
  logic [31:0] out;
  logic        error;
  logic        ready;
  logic        sram_en;
  logic        sram_we;
  logic [29:0] sram_addr;
  logic [3:0]  sram_be;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = 32'hDEAD_BEEF;

  logic        aux_rd = 1'b1;
  logic [31:0] a1_out, a15_out, a1_wd, a15_wd;
  logic        a1_err, a1_rdy, a1_en, a1_we, a15_err, a15_rdy, a15_en, a15_we;
  logic [29:0] a1_sa, a15_sa;
  logic [3:0]  a1_be, a15_be;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Main device under test at the default latency
  mem_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .rd(rd), .we(we), .addr(addr), .data(data),
    .size(size), .sign(sign), .out(out), .error(error), .ready(ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_be(sram_be), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Latency sweep instances: continuous word loads from a fixed SRAM word
  mem_ctrl #(.LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .rd(aux_rd), .we(1'b0), .addr(32'h100), .data(32'd0),
    .size(2'b10), .sign(1'b0), .out(a1_out), .error(a1_err), .ready(a1_rdy),
    .sram_en(a1_en), .sram_we(a1_we), .sram_addr(a1_sa),
    .sram_be(a1_be), .sram_wdata(a1_wd), .sram_rdata(32'h8000_00F0)
  );

  mem_ctrl #(.LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .rd(aux_rd), .we(1'b0), .addr(32'h100), .data(32'd0),
    .size(2'b10), .sign(1'b0), .out(a15_out), .error(a15_err), .ready(a15_rdy),
    .sram_en(a15_en), .sram_we(a15_we), .sram_addr(a15_sa),
    .sram_be(a15_be), .sram_wdata(a15_wd), .sram_rdata(32'h8000_00F0)
  );

  always #5 clk = ~clk;

  // Shared comparison helper: every check in the bench funnels through here
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // SRAM behavioural model: read word appears exactly LAT cycles after the
  // strobe cycle, garbage at all other times; writes merge by byte enable.
  logic [31:0] sram_mem [int];
  int          sram_cd = 0;
  logic [31:0] sram_word;

  always @(posedge clk) begin
    if (sram_cd > 0) begin
      sram_cd--;
      sram_rdata <= (sram_cd == 0) ? sram_word : 32'hDEAD_BEEF;
    end else begin
      sram_rdata <= 32'hDEAD_BEEF;
    end
    if (!rst) sram_cd = 0;
    else if (sram_en && !sram_we) begin
      sram_word = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'd0;
      sram_cd = LAT - 1;
      if (sram_cd == 0) sram_rdata <= sram_word;
    end else if (sram_en && sram_we) begin
      logic [31:0] w;
      w = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 32'd0;
      for (int i = 0; i < 4; i++) if (sram_be[i]) w[8*i +: 8] = sram_wdata[8*i +: 8];
      sram_mem[int'(sram_addr)] = w;
    end
  end

  // Transaction model: per-cycle expectations keyed by absolute cycle number
  typedef struct {
    bit          en;
    bit          we;
    bit          rdy;
    bit          err;
    bit          a_chk;
    logic [3:0]  be;
    logic [29:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q [int];
  logic [31:0] out_upd [int];
  logic [31:0] model_mem [int];
  logic [31:0] model_out = 32'd0;
  int          model_free = 0;

  function automatic exp_t blank();
    exp_t e;
    e = '{default: '0};
    return e;
  endfunction

  // Work out the whole life of a request accepted at the end of cycle c0
  function automatic void model_accept(int c0);
    exp_t        e;
    logic [31:0] w;
    logic [31:0] v;
    int          off;
    bit          fault;
    off = int'(addr[1:0]);
    fault = (rd && we) || size == 2'b11 || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && off != 0);
    if (fault) begin
      e = blank(); e.rdy = 1; e.err = 1;
      exp_q[c0 + 1] = e;
      model_free = c0 + 2;
      return;
    end
    e = blank(); e.en = 1; e.we = we; e.a_chk = 1; e.wa = addr[31:2];
    case (size)
      2'b00:   begin e.be = 4'(1 << off); e.wd = {24'd0, data[7:0]} * 32'h0101_0101; end
      2'b01:   begin e.be = 4'(3 << (off & 2)); e.wd = {16'd0, data[15:0]} * 32'h0001_0001; end
      default: begin e.be = 4'hF; e.wd = data; end
    endcase
    exp_q[c0 + 1] = e;
    w = model_mem.exists(int'(addr[31:2])) ? model_mem[int'(addr[31:2])] : 32'd0;
    if (we) begin
      for (int i = 0; i < 4; i++) if (e.be[i]) w[8*i +: 8] = e.wd[8*i +: 8];
      model_mem[int'(addr[31:2])] = w;
      e = blank(); e.rdy = 1; e.a_chk = 1; e.wa = addr[31:2];
      exp_q[c0 + 2] = e;
      model_free = c0 + 3;
    end else begin
      e = blank(); e.a_chk = 1; e.wa = addr[31:2];
      for (int k = 2; k <= LAT + 1; k++) exp_q[c0 + k] = e;
      e.rdy = 1;
      exp_q[c0 + LAT + 2] = e;
      if (size == 2'b00) begin
        v = (w >> (8 * off)) & 32'h0000_00FF;
        if (!sign && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
        v = (w >> (8 * (off & 2))) & 32'h0000_FFFF;
        if (!sign && v[15]) v = v | 32'hFFFF_0000;
      end else begin
        v = w;
      end
      out_upd[c0 + LAT + 2] = v;
      model_free = c0 + LAT + 3;
    end
  endfunction

  // Model clock: accept when the model says the controller is idle;
  // reset discards everything in flight and clears the held result
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      out_upd.delete();
      model_out = 32'd0;
      model_free = 0;
    end else begin
      if (cyc >= model_free && (rd || we)) model_accept(cyc);
      cyc++;
    end
  end

  // Compare process: check every output against the model mid-cycle
  always @(negedge clk) begin
    exp_t e;
    e = exp_q.exists(cyc) ? exp_q[cyc] : blank();
    if (out_upd.exists(cyc)) model_out = out_upd[cyc];
    checkOutput("cyc_ready", 32'(ready), 32'(e.rdy));
    checkOutput("cyc_error", 32'(error), 32'(e.err));
    checkOutput("cyc_sram_en", 32'(sram_en), 32'(e.en));
    checkOutput("cyc_sram_we", 32'(sram_we), 32'(e.we));
    checkOutput("cyc_sram_be", 32'(sram_be), 32'(e.be));
    checkOutput("cyc_out", out, model_out);
    if (e.a_chk) checkOutput("cyc_sram_addr", 32'(sram_addr), 32'(e.wa));
    if (e.en && e.we) checkOutput("cyc_sram_wdata", sram_wdata, e.wd);
  end

  // Drive one request for one cycle, then observe it until ready (bounded)
  task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s, input logic sg,
                               output int en_k, output int rdy_k, output logic err_o,
                               output logic [31:0] out_o, output logic swe,
                               output logic [29:0] sa, output logic [3:0] sbe,
                               output logic [31:0] swd);
    en_k = -1; rdy_k = -1; err_o = 1'b0; out_o = 32'd0;
    swe = 1'b0; sa = 30'd0; sbe = 4'd0; swd = 32'd0;
    @(posedge clk); #2;
    rd = r; we = w; addr = a; data = d; size = s; sign = sg;
    @(posedge clk); #2;
    rd = 1'b0; we = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (sram_en && en_k < 0) begin
        en_k = k; swe = sram_we; sa = sram_addr; sbe = sram_be; swd = sram_wdata;
      end
      if (ready) begin
        rdy_k = k; err_o = error; out_o = out;
        break;
      end
    end
    if (rdy_k < 0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL ready_timeout: no ready within 40 cycles, expected one");
    end
  endtask

  function automatic logic readyOf(input int which);
    case (which)
      1:       return a1_rdy;
      2:       return a15_rdy;
      default: return ready;
    endcase
  endfunction

  // Spacing of completions while rd stays high; every high cycle counts
  // as a pulse so a stretched ready shows up as a short gap
  task automatic measureGaps(input int which, input int lat, input string name);
    int pulses[3];
    int np = 0;
    for (int k = 0; k < 3 * (lat + 3) + 20 && np < 3; k++) begin
      @(negedge clk);
      if (readyOf(which)) begin
        pulses[np] = cyc;
        np++;
        if (which == 1) begin
          checkOutput({name, "_out"}, a1_out, 32'h8000_00F0);
          checkOutput({name, "_err"}, 32'(a1_err), 32'd0);
          checkOutput({name, "_en"}, 32'({a1_en, a1_we, a1_be}), 32'd0);
          checkOutput({name, "_sa"}, 32'(a1_sa), 32'h40);
        end else if (which == 2) begin
          checkOutput({name, "_out"}, a15_out, 32'h8000_00F0);
          checkOutput({name, "_err"}, 32'(a15_err), 32'd0);
          checkOutput({name, "_en"}, 32'({a15_en, a15_we, a15_be}), 32'd0);
          checkOutput({name, "_sa"}, 32'(a15_sa), 32'h40);
        end
      end
    end
    if (np < 3) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s_timeout: saw %0d completions, expected 3", name, np);
    end else begin
      checkOutput({name, "_gap1"}, 32'(pulses[1] - pulses[0]), 32'(lat + 3));
      checkOutput({name, "_gap2"}, 32'(pulses[2] - pulses[1]), 32'(lat + 3));
    end
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  s;
    logic        sg;
    int          x_en;
    int          x_rdy;
    logic        x_err;
    logic [31:0] x_out;
    logic [29:0] x_sa;
    logic [3:0]  x_be;
    logic [31:0] x_wd;
  } vec_t;

  vec_t        vecs [15];
  int          en_k, rdy_k;
  logic        err_o, swe;
  logic [31:0] out_o, swd;
  logic [29:0] sa;
  logic [3:0]  sbe;

  // Directed sequence with hand-computed results (SRAM word 0x8000_00F0 at 0x100)
  initial begin
    vecs = '{
      '{1, 0, 32'h100, 32'h0,         2'b00, 0,  1, 4, 0, 32'hFFFF_FFF0, 30'h40, 4'b0001, 32'h0},
      '{1, 0, 32'h102, 32'h0,         2'b01, 1,  1, 4, 0, 32'h0000_8000, 30'h40, 4'b1100, 32'h0},
      '{1, 0, 32'h100, 32'h0,         2'b10, 0,  1, 4, 0, 32'h8000_00F0, 30'h40, 4'b1111, 32'h0},
      '{1, 0, 32'h103, 32'h0,         2'b00, 0,  1, 4, 0, 32'hFFFF_FF80, 30'h40, 4'b1000, 32'h0},
      '{1, 0, 32'h100, 32'h0,         2'b01, 0,  1, 4, 0, 32'h0000_00F0, 30'h40, 4'b0011, 32'h0},
      '{0, 1, 32'h203, 32'h1234_56AB, 2'b00, 0,  1, 2, 0, 32'h0000_00F0, 30'h80, 4'b1000, 32'hABAB_ABAB},
      '{1, 0, 32'h203, 32'h0,         2'b00, 1,  1, 4, 0, 32'h0000_00AB, 30'h80, 4'b1000, 32'h0},
      '{0, 1, 32'h206, 32'hCAFE_BEEF, 2'b01, 0,  1, 2, 0, 32'h0000_00AB, 30'h81, 4'b1100, 32'hBEEF_BEEF},
      '{1, 0, 32'h206, 32'h0,         2'b01, 0,  1, 4, 0, 32'hFFFF_BEEF, 30'h81, 4'b1100, 32'h0},
      '{1, 0, 32'h102, 32'h0,         2'b10, 0, -1, 1, 1, 32'hFFFF_BEEF, 30'h0,  4'b0000, 32'h0},
      '{1, 1, 32'h100, 32'h0,         2'b00, 0, -1, 1, 1, 32'hFFFF_BEEF, 30'h0,  4'b0000, 32'h0},
      '{1, 0, 32'h100, 32'h0,         2'b11, 0, -1, 1, 1, 32'hFFFF_BEEF, 30'h0,  4'b0000, 32'h0},
      '{1, 0, 32'h101, 32'h0,         2'b01, 0, -1, 1, 1, 32'hFFFF_BEEF, 30'h0,  4'b0000, 32'h0},
      '{0, 1, 32'h208, 32'h1357_9BDF, 2'b10, 0,  1, 2, 0, 32'hFFFF_BEEF, 30'h82, 4'b1111, 32'h1357_9BDF},
      '{1, 0, 32'h208, 32'h0,         2'b10, 0,  1, 4, 0, 32'h1357_9BDF, 30'h82, 4'b1111, 32'h0}
    };
    sram_mem[32'h40] = 32'h8000_00F0;
    model_mem[32'h40] = 32'h8000_00F0;

    // Asynchronous reset takes effect before any clock edge
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_out", out, 32'd0);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    checkOutput("reset_sram", 32'({sram_en, sram_we, sram_be}), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, vecs[i].sg,
                    en_k, rdy_k, err_o, out_o, swe, sa, sbe, swd);
      checkOutput($sformatf("vec%0d_en_cycle", i), 32'(en_k), 32'(vecs[i].x_en));
      checkOutput($sformatf("vec%0d_ready_cycle", i), 32'(rdy_k), 32'(vecs[i].x_rdy));
      checkOutput($sformatf("vec%0d_error", i), 32'(err_o), 32'(vecs[i].x_err));
      checkOutput($sformatf("vec%0d_out", i), out_o, vecs[i].x_out);
      if (vecs[i].x_en > 0) begin
        checkOutput($sformatf("vec%0d_sram_we", i), 32'(swe), 32'(vecs[i].w));
        checkOutput($sformatf("vec%0d_sram_addr", i), 32'(sa), 32'(vecs[i].x_sa));
        checkOutput($sformatf("vec%0d_sram_be", i), 32'(sbe), 32'(vecs[i].x_be));
        if (vecs[i].w) checkOutput($sformatf("vec%0d_sram_wdata", i), swd, vecs[i].x_wd);
      end
    end

    // Reset in the middle of a load's wait phase abandons it at once
    @(posedge clk); #2;
    rd = 1'b1; size = 2'b10; addr = 32'h100; sign = 1'b0;
    @(posedge clk); #2;
    rd = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_out", out, 32'd0);
    checkOutput("midrst_ready", 32'(ready), 32'd0);
    checkOutput("midrst_sram", 32'({sram_en, sram_we, sram_be}), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h20C, 32'h5555_1234, 2'b01, 1'b0,
                  en_k, rdy_k, err_o, out_o, swe, sa, sbe, swd);
    checkOutput("postrst_en_cycle", 32'(en_k), 32'd1);
    checkOutput("postrst_ready_cycle", 32'(rdy_k), 32'd2);
    checkOutput("postrst_out", out_o, 32'd0);
    checkOutput("postrst_sram_be", 32'(sbe), 32'b0011);
    checkOutput("postrst_sram_wdata", swd, 32'h1234_1234);
    checkOutput("postrst_sram_addr", 32'(sa), 32'h83);

    // Back-to-back loads with rd held high
    @(posedge clk); #2;
    rd = 1'b1; size = 2'b10; addr = 32'h100; sign = 1'b0;
    measureGaps(0, LAT, "b2b_lat2");
    rd = 1'b0;
    repeat (10) @(posedge clk);
    measureGaps(1, 1, "b2b_lat1");
    measureGaps(2, 15, "b2b_lat15");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Last-resort guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning SRAM read latency in cycles from the sram_en cycle to the sram_rdata valid cycle (legal 1..15).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port rd  input  1  CPU load request.
REQ-005 SHALL have port we  input  1  CPU store request.
REQ-006 SHALL have port addr  input  32  CPU byte address.
REQ-007 SHALL have port data  input  32  CPU store data, right-aligned.
REQ-008 SHALL have port size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port sign  input  1  load extension: 0 sign-extend, 1 zero-extend (funct3[2] encoding).
REQ-010 SHALL have port out  output  32  formatted load result.
REQ-011 SHALL have port error  output  1  access fault, valid while ready=1.
REQ-012 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-013 SHALL have port sram_en  output  1  SRAM access strobe.
REQ-014 SHALL have port sram_we  output  1  SRAM write strobe, only with sram_en.
REQ-015 SHALL have port sram_addr  output  30  word address (addr[31:2]).
REQ-016 SHALL have port sram_be  output  4  byte-lane enables.
REQ-017 SHALL have port sram_wdata  output  32  lane-replicated store data.
REQ-018 SHALL have port sram_rdata  input  32  SRAM read data.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered or decoded from registered state only.
REQ-020 SHALL accept a request only in IDLE when rd|we=1; capture addr, data, size, sign, rd, we into registers; rd/we outside IDLE ignored.
REQ-021 SHALL flag fault at acceptance when: rd&we both 1; size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=00.
REQ-022 Faulted request: IDLE->RESP directly, no sram_en, ready=1 and error=1 in cycle 1 (acceptance = cycle 0), out unchanged.
REQ-023 Store: IDLE->ISSUE (cycle 1: sram_en=1, sram_we=1) ->RESP (cycle 2: ready=1, error=0) ->IDLE.
REQ-024 Load: IDLE->ISSUE (cycle 1: sram_en=1, sram_we=0) ->WAIT for LATENCY cycles (cycles 2..LATENCY+1), sram_rdata sampled at end of cycle LATENCY+1 ->RESP (cycle LATENCY+2: ready=1, out valid).
REQ-025 WAIT SHALL use a 4-bit down-counter loaded with LATENCY-1 on ISSUE exit; WAIT exits when counter=0.
REQ-026 RESP SHALL last exactly one cycle and return to IDLE; a request present in that RESP cycle is ignored; next acceptance earliest in following IDLE cycle.
REQ-027 sram_be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111; 0000 when sram_en=0.
REQ-028 sram_wdata: byte {4{data[7:0]}}; half {2{data[15:0]}}; word data.
REQ-029 Load format: select byte lane addr[1:0] or half lane addr[1]; extend to 32 bits per sign; word passes unchanged.
REQ-030 out SHALL hold last load result until next successful load; stores and faults do not modify it.
REQ-031 sram_addr SHALL hold captured addr[31:2] from ISSUE through RESP.

Reset
REQ-032 rst=0 SHALL immediately, without clock, force state IDLE, counter 0, out=0, error=0, ready=0, sram_en=0, sram_we=0, sram_be=0.
REQ-033 Reset mid-transaction SHALL abandon it with no ready pulse; first request after rst release accepted normally.

Verification
REQ-034 LATENCY=2, SRAM word 0x8000_00F0 at 0x100; rd, size=00, sign=0, addr=0x100 -> sram_en cycle 1, ready cycle 4, out=0xFFFF_FFF0.
REQ-035 Same word; rd, size=01, sign=1, addr=0x102 -> out=0x0000_8000; size=10 addr=0x100 -> out=0x8000_00F0.
REQ-036 we, size=00, addr=0x203, data=0x1234_56AB -> cycle 1 sram_en=1, sram_we=1, sram_addr=0x80, sram_be=1000, sram_wdata=0xABAB_ABAB; ready cycle 2.
REQ-037 rd, size=10, addr=0x102 -> ready=1, error=1 cycle 1, sram_en never asserted, out unchanged; repeat with rd=we=1 and size=11 -> same.
REQ-038 Load accepted, rst=0 asserted in WAIT -> sram_en/ready/out=0 immediately, no ready pulse; after release, store completes in 2 cycles.
REQ-039 Back-to-back rd held high continuously -> one completion per LATENCY+3 cycles, each with ready single-cycle; sweep LATENCY=1 and 15.
